// File: rtl/game_status_checker.sv
// game_status_checker
// Win/draw detector for a 4x4 Connect-4 board. On a start request the
// occupancy and ownership vectors are snapshotted, then the ten candidate
// lines (4 rows, 4 columns, 2 diagonals) are scanned one per clock. The
// first winning line in scan order decides the result. A full board with
// no winner reports draw when DRAW_ENABLE is non-zero. Once a non-playing
// status is reported the block parks in OVER until reset.

module game_status_checker #(
  parameter int DRAW_ENABLE = 1
) (
  input  logic        clk,
  input  logic        reset,            // asynchronous, active-low
  input  logic        start,
  input  logic [15:0] in_gameboard,
  input  logic [15:0] in_players_cells,
  output logic [1:0]  out_game_status,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [1:0] ST_PLAYING = 2'b00;
  localparam logic [1:0] ST_P1_WIN  = 2'b01;
  localparam logic [1:0] ST_P2_WIN  = 2'b10;
  localparam logic [1:0] ST_DRAW    = 2'b11;

  localparam logic [3:0]  LAST_IDX   = 4'd9;
  localparam logic [15:0] FULL_BOARD = 16'hFFFF;
  localparam bit          DRAW_EN    = (DRAW_ENABLE != 0);

  // Cell mask of candidate line idx; bit index = row*4 + col, row 0 = bottom.
  function automatic logic [15:0] line_mask(input logic [3:0] idx);
    logic [15:0] m;
    case (idx)
      4'd0:    m = 16'h000F;   // row 0
      4'd1:    m = 16'h00F0;   // row 1
      4'd2:    m = 16'h0F00;   // row 2
      4'd3:    m = 16'hF000;   // row 3
      4'd4:    m = 16'h1111;   // column 0
      4'd5:    m = 16'h2222;   // column 1
      4'd6:    m = 16'h4444;   // column 2
      4'd7:    m = 16'h8888;   // column 3
      4'd8:    m = 16'h8421;   // diagonal {0,5,10,15}
      4'd9:    m = 16'h1248;   // anti-diagonal {3,6,9,12}
      default: m = 16'h0000;   // unreachable; an empty mask never wins
    endcase
    return m;
  endfunction

  state_t      state_q,   state_d;
  logic [3:0]  idx_q,     idx_d;
  logic [15:0] board_q,   board_d;
  logic [15:0] players_q, players_d;
  logic [1:0]  status_q,  status_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;

  logic [15:0] cur_mask;
  logic [15:0] cur_owner;
  logic        line_full;
  logic        line_same_owner;
  logic        line_win;
  logic [1:0]  win_status;
  logic        board_full;

  // Evaluate the current candidate line against the snapshot.
  always_comb begin
    cur_mask        = line_mask(idx_q);
    cur_owner       = players_q & cur_mask;
    // Occupancy and ownership are both checked only through the mask, so
    // owner bits of empty cells never influence the result.
    line_full       = (cur_mask != 16'h0000) && ((board_q & cur_mask) == cur_mask);
    line_same_owner = (cur_owner == 16'h0000) || (cur_owner == cur_mask);
    line_win        = line_full && line_same_owner;
    win_status      = (cur_owner == 16'h0000) ? ST_P1_WIN : ST_P2_WIN;
    board_full      = (board_q == FULL_BOARD);
  end

  // Next-state and registered-output logic of the scan controller.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    board_d   = board_q;
    players_d = players_q;
    status_d  = status_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // A finished game never returns here, but the status guard keeps
        // the acceptance rule explicit.
        if (start && (status_q == ST_PLAYING)) begin
          board_d   = in_gameboard;
          players_d = in_players_cells;
          idx_d     = 4'd0;
          busy_d    = 1'b1;
          state_d   = SCAN;
        end
      end

      SCAN: begin
        if (line_win) begin
          status_d = win_status;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (idx_q == LAST_IDX) begin
          status_d = (DRAW_EN && board_full) ? ST_DRAW : ST_PLAYING;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = (status_q != ST_PLAYING) ? OVER : IDLE;
      end

      OVER: begin
        // Result is frozen; only reset leaves this state.
        busy_d = 1'b0;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, snapshot and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      board_q   <= 16'h0000;
      players_q <= 16'h0000;
      status_q  <= ST_PLAYING;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      board_q   <= board_d;
      players_q <= players_d;
      status_q  <= status_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out_game_status = status_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
